// File: rtl/gpu_mem_pkg.sv
// Constants shared by the edge-load stage and the triangle assembler so that
// edge-word packing and the assembler state encoding stay consistent.
package gpu_mem_pkg;

   // Width of one vertex index inside an edge word
   localparam int IDX_W  = 16;

   // Bit offsets of the three indices inside an edge word {i2,i1,i0}
   localparam int I0_LSB = 0;
   localparam int I1_LSB = 16;
   localparam int I2_LSB = 32;

   // Triangle assembler walk states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      E_RD  = 3'd1,
      E_CAP = 3'd2,
      V0    = 3'd3,
      V1    = 3'd4,
      V2    = 3'd5,
      EMIT  = 3'd6
   } tri_state_e;

endpackage

// File: rtl/tri_assemble.sv
// Triangle assembler: walks a range of edge RAM entries, fetches the three
// referenced vertices from vertex RAM and hands out one triangle per
// valid/ready handshake.
module tri_assemble
   import gpu_mem_pkg::*;
#(
   parameter int EDGE_DEPTH = 1024,
   parameter int EDGE_DW    = 48,
   parameter int VTX_DEPTH  = 1024,
   parameter int VTX_DW     = 48
)(
   input  logic                          CLK,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(EDGE_DEPTH)-1:0] first,
   input  logic [$clog2(EDGE_DEPTH):0]   count,
   output logic [$clog2(EDGE_DEPTH)-1:0] edge_raddr,
   output logic                          edge_re,
   input  logic [EDGE_DW-1:0]            edge_rdata,
   output logic [$clog2(VTX_DEPTH)-1:0]  vtx_raddr,
   output logic                          vtx_re,
   input  logic [VTX_DW-1:0]             vtx_rdata,
   output logic                          tri_valid,
   input  logic                          tri_ready,
   output logic [VTX_DW-1:0]             tri_v0,
   output logic [VTX_DW-1:0]             tri_v1,
   output logic [VTX_DW-1:0]             tri_v2,
   output logic                          tri_last,
   output logic                          BUSY,
   output logic                          done,
   output logic                          err_range
);

   localparam int EA_W = $clog2(EDGE_DEPTH);
   localparam int VA_W = $clog2(VTX_DEPTH);

   // Range end is computed two bits wider than an address so first+count never wraps
   localparam logic [EA_W+1:0] EDGE_LIM = (EA_W+2)'(EDGE_DEPTH);
   // Vertex bound kept one bit wider than an index so VTX_DEPTH=2^16 still compares correctly
   localparam logic [IDX_W:0]  VTX_LIM  = (IDX_W+1)'(VTX_DEPTH);
   localparam logic [EA_W-1:0] CUR_ONE  = EA_W'(1);
   localparam logic [EA_W:0]   REM_ONE  = (EA_W+1)'(1);

   tri_state_e       state;
   tri_state_e       state_nx;

   logic [EA_W-1:0]  cur;
   logic [EA_W:0]    remaining;
   logic [VA_W-1:0]  idx1_lo;
   logic [VA_W-1:0]  idx2_lo;

   logic [IDX_W-1:0] e_i0;
   logic [IDX_W-1:0] e_i1;
   logic [IDX_W-1:0] e_i2;
   logic [EA_W+1:0]  range_end;
   logic             range_bad;
   logic             idx_bad;
   logic             accept;
   logic             handshake;
   logic             last_one;

   assign e_i0      = edge_rdata[I0_LSB +: IDX_W];
   assign e_i1      = edge_rdata[I1_LSB +: IDX_W];
   assign e_i2      = edge_rdata[I2_LSB +: IDX_W];

   assign range_end = {2'b00, first} + {1'b0, count};
   assign range_bad = (range_end > EDGE_LIM);

   // Full 16-bit indices are checked, not just the bits that reach vtx_raddr
   assign idx_bad   = ({1'b0, e_i0} >= VTX_LIM) ||
                      ({1'b0, e_i1} >= VTX_LIM) ||
                      ({1'b0, e_i2} >= VTX_LIM);

   assign accept    = (state == IDLE) && start;
   assign handshake = (state == EMIT) && tri_ready;
   assign last_one  = (remaining == REM_ONE);

   assign tri_valid = (state == EMIT);
   assign BUSY      = (state != IDLE);

   // State register
   always_ff @(posedge CLK) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and RAM read-port decode; reads are issued only in their issue states
   always_comb begin
      state_nx   = state;
      edge_re    = 1'b0;
      edge_raddr = '0;
      vtx_re     = 1'b0;
      vtx_raddr  = '0;
      case (state)
         IDLE: begin
            if (start && !range_bad && (count != '0)) begin
               state_nx = E_RD;
            end
         end
         E_RD: begin
            edge_re    = 1'b1;
            edge_raddr = cur;
            state_nx   = E_CAP;
         end
         E_CAP: begin
            if (idx_bad) begin
               state_nx = IDLE;
            end else begin
               // i0 is taken straight off the RAM bus so its fetch overlaps the capture
               vtx_re    = 1'b1;
               vtx_raddr = e_i0[VA_W-1:0];
               state_nx  = V0;
            end
         end
         V0: begin
            vtx_re    = 1'b1;
            vtx_raddr = idx1_lo;
            state_nx  = V1;
         end
         V1: begin
            vtx_re    = 1'b1;
            vtx_raddr = idx2_lo;
            state_nx  = V2;
         end
         V2: begin
            state_nx = EMIT;
         end
         EMIT: begin
            if (tri_ready) begin
               state_nx = last_one ? IDLE : E_RD;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Walk counters, captured indices/vertices and status flags
   always_ff @(posedge CLK) begin
      if (rst) begin
         cur       <= '0;
         remaining <= '0;
         idx1_lo   <= '0;
         idx2_lo   <= '0;
         tri_v0    <= '0;
         tri_v1    <= '0;
         tri_v2    <= '0;
         tri_last  <= 1'b0;
         done      <= 1'b0;
         err_range <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            cur       <= first;
            remaining <= count;
            err_range <= range_bad;
            done      <= !range_bad && (count == '0);
         end
         case (state)
            E_CAP: begin
               idx1_lo <= e_i1[VA_W-1:0];
               idx2_lo <= e_i2[VA_W-1:0];
               if (idx_bad) begin
                  err_range <= 1'b1;
               end
            end
            V0: tri_v0 <= vtx_rdata;
            V1: tri_v1 <= vtx_rdata;
            V2: begin
               tri_v2   <= vtx_rdata;
               tri_last <= last_one;
            end
            EMIT: begin
               if (handshake) begin
                  tri_last <= 1'b0;
                  if (last_one) begin
                     done <= 1'b1;
                  end else begin
                     remaining <= remaining - REM_ONE;
                     cur       <= cur + CUR_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_assemble.sv
// Bench for tri_assemble: RAM models, a handshake monitor and a walk-level
// reference model derived from the edge/vertex contents.
module tb_tri_assemble;

   localparam int ED = 1024;
   localparam int VD = 1024;

   typedef struct packed {
      logic [47:0] v0;
      logic [47:0] v1;
      logic [47:0] v2;
      logic        last;
   } tri_t;

   logic        CLK;
   logic        rst;
   logic        start;
   logic [9:0]  first_i;
   logic [10:0] count_i;
   logic [9:0]  edge_raddr;
   logic        edge_re;
   logic [47:0] edge_rdata;
   logic [9:0]  vtx_raddr;
   logic        vtx_re;
   logic [47:0] vtx_rdata;
   logic        tri_valid;
   logic        tri_ready;
   logic [47:0] tri_v0;
   logic [47:0] tri_v1;
   logic [47:0] tri_v2;
   logic        tri_last;
   logic        BUSY;
   logic        done;
   logic        err_range;

   logic [47:0] edge_mem [ED];
   logic [47:0] vtx_mem  [VD];

   int   n_assert = 0;
   int   n_fail   = 0;

   tri_t got_q[$];
   tri_t exp_q[$];
   bit   exp_err;
   int   exp_reads;

   int   cyc       = 0;
   int   hs_cyc    = 0;
   int   done_cyc  = 0;
   int   done_cnt  = 0;
   int   ere_cnt   = 0;
   int   stall_bad = 0;
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;
   tri_t prev_tri;

   tri_assemble #(
      .EDGE_DEPTH(ED), .EDGE_DW(48), .VTX_DEPTH(VD), .VTX_DW(48)
   ) dut (
      .CLK(CLK), .rst(rst), .start(start), .first(first_i), .count(count_i),
      .edge_raddr(edge_raddr), .edge_re(edge_re), .edge_rdata(edge_rdata),
      .vtx_raddr(vtx_raddr), .vtx_re(vtx_re), .vtx_rdata(vtx_rdata),
      .tri_valid(tri_valid), .tri_ready(tri_ready),
      .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_last(tri_last),
      .BUSY(BUSY), .done(done), .err_range(err_range)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous-read RAMs, one cycle latency
   always @(posedge CLK) begin
      if (edge_re) edge_rdata <= edge_mem[edge_raddr];
      if (vtx_re)  vtx_rdata  <= vtx_mem[vtx_raddr];
   end

   // Monitor: handshakes, done pulses, edge reads and stall stability
   always @(negedge CLK) begin
      tri_t now_tri;
      cyc = cyc + 1;
      now_tri = '{v0: tri_v0, v1: tri_v1, v2: tri_v2, last: tri_last};
      if (tri_valid && tri_ready) begin
         got_q.push_back(now_tri);
         hs_cyc = cyc;
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (edge_re) ere_cnt = ere_cnt + 1;
      if (prev_valid && !prev_ready && tri_valid && (now_tri !== prev_tri))
         stall_bad = stall_bad + 1;
      prev_valid = tri_valid;
      prev_ready = tri_ready;
      prev_tri   = now_tri;
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] pack_edge(input int i0, input int i1, input int i2);
      logic [15:0] a, b, c;
      a = 16'(i0);
      b = 16'(i1);
      c = 16'(i2);
      return {c, b, a};
   endfunction

   // Reference: what a walk of (f,c) must produce given current RAM contents
   task automatic model_walk(input int f, input int c);
      logic [47:0] w;
      int i0, i1, i2;
      exp_q.delete();
      exp_err   = 1'b0;
      exp_reads = 0;
      if (f + c > ED) begin
         exp_err = 1'b1;
         return;
      end
      for (int e = 0; e < c; e++) begin
         w = edge_mem[f + e];
         exp_reads++;
         i0 = int'(w[15:0]);
         i1 = int'(w[31:16]);
         i2 = int'(w[47:32]);
         if (i0 >= VD || i1 >= VD || i2 >= VD) begin
            exp_err = 1'b1;
            return;
         end
         exp_q.push_back('{v0: vtx_mem[i0], v1: vtx_mem[i1], v2: vtx_mem[i2], last: (e == c - 1)});
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk(tag, {tri_valid, BUSY, done, err_range, edge_re, vtx_re, tri_last,
                edge_raddr, vtx_raddr, tri_v0, tri_v1, tri_v2}, '0);
   endtask

   // Run one walk; mode 0 = tri_ready held high, mode 1 = ready one cycle in three
   task automatic run_walk(input string tag, input int f, input int c, input int mode, input bit inject);
      int fv, base_done, base_ere, n;
      bit finished;
      model_walk(f, c);
      got_q.delete();
      base_done = done_cnt;
      base_ere  = ere_cnt;
      stall_bad = 0;
      fv        = -1;
      finished  = 1'b0;
      @(posedge CLK); #1;
      start   = 1'b1;
      first_i = 10'(f);
      count_i = 11'(c);
      for (int k = 1; k <= 3000; k++) begin
         @(posedge CLK); #1;
         if (k == 1) start = 1'b0;
         if (inject && k == 3) begin
            start   = 1'b1;
            first_i = 10'd0;
            count_i = 11'd3;
         end
         if (inject && k == 4) start = 1'b0;
         tri_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         @(negedge CLK);
         if (tri_valid && fv < 0) fv = k;
         if (!BUSY) begin
            finished = 1'b1;
            break;
         end
      end
      chk({tag, "_finished"}, finished, 1'b1);
      tri_ready = 1'b0;
      repeat (2) @(negedge CLK);
      n = exp_q.size();
      chk({tag, "_ntri"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++)
         chk($sformatf("%s_tri%0d", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_valid_seen"}, (fv >= 0), (n > 0));
      if (n > 0) chk({tag, "_latency"}, fv - 1, 5);
      chk({tag, "_done_cnt"}, done_cnt - base_done, exp_err ? 0 : 1);
      if (n > 0 && !exp_err) chk({tag, "_done_timing"}, done_cyc - hs_cyc, 1);
      chk({tag, "_err_range"}, err_range, exp_err);
      chk({tag, "_edge_reads"}, ere_cnt - base_ere, exp_reads);
      chk({tag, "_busy"}, BUSY, 1'b0);
      chk({tag, "_stall_stable"}, stall_bad, 0);
   endtask

   initial begin
      int base_done;
      bit reached;
      rst       = 1'b1;
      start     = 1'b0;
      first_i   = '0;
      count_i   = '0;
      tri_ready = 1'b0;
      for (int k = 0; k < VD; k++) vtx_mem[k] = 48'hA000 + 48'(k);
      for (int k = 0; k < ED; k++)
         edge_mem[k] = pack_edge($urandom_range(0, VD - 1), $urandom_range(0, VD - 1), $urandom_range(0, VD - 1));

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_idle_zero("reset_state");
      @(posedge CLK); #1;
      rst = 1'b0;

      // Single triangle with known vertex values
      edge_mem[3] = pack_edge(0, 1, 2);
      run_walk("single", 3, 1, 0, 1'b0);

      // Four triangles with a stalling consumer
      run_walk("stall4", 10, 4, 1, 1'b0);

      // Out-of-range vertex index, then recovery
      edge_mem[0] = pack_edge(5, 1024, 7);
      run_walk("bad_idx", 0, 1, 0, 1'b0);
      run_walk("recover", 5, 2, 0, 1'b0);

      // Edge range boundary
      run_walk("range_over", 1020, 5, 0, 1'b0);
      run_walk("range_edge", 1020, 4, 1, 1'b0);

      // Empty walk and ignored start
      run_walk("count0", 7, 0, 0, 1'b0);
      run_walk("ign_start", 30, 3, 0, 1'b1);

      // Reset while a triangle is waiting
      @(posedge CLK); #1;
      start   = 1'b1;
      first_i = 10'd20;
      count_i = 11'd2;
      @(posedge CLK); #1;
      start   = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (tri_valid) begin
            reached = 1'b1;
            break;
         end
      end
      chk("emit_reached", reached, 1'b1);
      base_done = done_cnt;
      @(posedge CLK); #1;
      rst = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check_idle_zero("reset_in_emit");
      @(posedge CLK); #1;
      rst = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_no_done", done_cnt - base_done, 0);
      run_walk("after_reset", 40, 2, 0, 1'b0);

      // Randomized contents and walks
      for (int k = 0; k < VD; k++) vtx_mem[k] = 48'({$urandom(), $urandom()});
      for (int k = 0; k < ED; k++) begin
         edge_mem[k] = pack_edge($urandom_range(0, VD - 1), $urandom_range(0, VD - 1), $urandom_range(0, VD - 1));
         if ($urandom_range(0, 15) == 0)
            edge_mem[k][16 * $urandom_range(0, 2) +: 16] = 16'($urandom_range(VD, 65535));
      end
      for (int r = 0; r < 10; r++) begin
         int f, c;
         f = ($urandom_range(0, 3) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1023);
         c = $urandom_range(0, 6);
         run_walk($sformatf("rnd%0d", r), f, c, $urandom_range(0, 1), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
